// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared constants and helpers for the load/store unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_BUS  = 2'b01;
    localparam logic [1:0] c_ST_DONE = 2'b10;

    localparam logic [3:0] c_BE_BYTE = 4'b0001;
    localparam logic [3:0] c_BE_HLO  = 4'b0011;
    localparam logic [3:0] c_BE_HHI  = 4'b1100;
    localparam logic [3:0] c_BE_WORD = 4'b1111;

    // Stores only have B/H/W encodings; loads additionally allow BU/HU.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_load,
                                        input logic [1:0] lo);
        logic bad_enc;
        logic bad_align;
        bad_enc = is_load ? ((f3 == 3'b011) || (f3[2:1] == 2'b11)) : (f3 >= 3'b011);
        case (f3[1:0])
            2'b01:   bad_align = lo[0];
            2'b10:   bad_align = |lo;
            default: bad_align = 1'b0;
        endcase
        return bad_enc | bad_align;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// Module : load_extract
// Brief  : Load lane select with sign/zero extension (combinational).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            c_F3_B:  o_result = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: o_result = {24'h0, w_byte};
            c_F3_H:  o_result = {{16{w_half[15]}}, w_half};
            c_F3_HU: o_result = {16'h0, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : RV32I memory stage: one req/ack bus transaction per load/store,
//          stalling the core. Define LSU_TIMEOUT_EN to add a bus timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;

    logic              w_access;
    logic              w_illegal;
    logic              w_start;
    logic              w_timeout;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load_data;

    assign w_access  = mem_read | mem_write;
    assign w_illegal = f3_illegal(funct3, mem_read, addr[1:0]);
    assign w_start   = (r_state == c_ST_IDLE) & w_access & ~w_illegal;

    assign misaligned = (r_state == c_ST_IDLE) & w_access & w_illegal;
    assign stall      = w_start | (r_state == c_ST_BUS);
    // A rejected access must not forward stale data to writeback.
    assign rdata      = misaligned ? '0 : r_rdata;

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

    always_comb begin
        w_be    = c_BE_WORD;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be    = c_BE_BYTE << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? c_BE_HHI : c_BE_HLO;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = c_BE_WORD;
                w_wdata = wdata;
            end
        endcase
    end

    load_extract u_extract (
        .i_word    (bus_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_result  (w_load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bus_fault;

    // Fires on the BUS cycle whose un-acked completion brings the count to TIMEOUT_CYC.
    assign w_timeout = (r_state == c_ST_BUS) & ~bus_ack & (r_cnt == c_CNT_LAST);
    assign bus_fault = r_bus_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bus_fault <= 1'b0;
        end else begin
            r_bus_fault <= w_timeout;
            if (w_start) begin
                r_cnt <= '0;
            end else if ((r_state == c_ST_BUS) && !bus_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_fault = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start) w_next = c_ST_BUS;
            c_ST_BUS:  if (bus_ack || w_timeout) w_next = c_ST_DONE;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= mem_write & ~mem_read;
                r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
                r_funct3    <= funct3;
                r_addr_lo   <= addr[1:0];
            end else if ((r_state == c_ST_BUS) && (bus_ack || w_timeout)) begin
                r_bus_req <= 1'b0;
                r_rdata   <= bus_ack ? w_load_data : '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Self-checking bench for load_store_unit with a behavioural model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_fault  (bus_fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    typedef struct {
        logic        mis;
        logic        stall0;
        logic [31:0] rdata0;
        logic        req_bad;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] bwdata;
        int          stall_cnt;
        logic        done_req;
        logic        done_fault;
        logic [31:0] rdata_done;
        logic        timed_out;
        logic        reissue;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_mis(input logic is_load, input logic [2:0] f3, input logic [31:0] a);
        if (is_load && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (!is_load && f3 >= 3) return 1'b1;
        return (a % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << acc_bytes(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (acc_bytes(f3) == 1) return (d & 32'hFF) * 32'h01010101;
        if (acc_bytes(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int n;
        n = acc_bytes(f3);
        if (n == 4) return w;
        v = (w >> (8 * (a % 4))) & ((32'h1 << (8 * n)) - 1);
        if (!f3[2] && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
        return v;
    endfunction

    // ---------------- transaction driver (no checks) ----------------
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_at, output obs_t o);
        int k;
        bit fin;
        o = '{default: '0};
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        o.mis = misaligned; o.stall0 = stall; o.rdata0 = rdata;
        if (!stall) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                mem_read = 1'b0; mem_write = 1'b0;
                if (bus_req !== 1'b0) o.req_bad = 1'b1;
            end
        end else begin
            o.stall_cnt = 1;
            k = 0; fin = 0;
            while (!fin && k < 400) begin
                @(posedge clk); #1;
                k++;
                bus_ack = 1'b0;
                if (!stall) begin
                    fin = 1;
                    o.done_req = bus_req; o.done_fault = bus_fault; o.rdata_done = rdata;
                end else begin
                    o.stall_cnt++;
                    if (bus_req !== 1'b1) o.req_bad = 1'b1;
                    if (k == 1) begin
                        o.baddr = bus_addr; o.be = bus_be; o.we = bus_we; o.bwdata = bus_wdata;
                    end else if (bus_addr !== o.baddr || bus_be !== o.be || bus_we !== o.we
                                 || bus_wdata !== o.bwdata) begin
                        o.req_bad = 1'b1;
                    end
                    if (k == ack_at) begin bus_rdata = rdat; bus_ack = 1'b1; end
                end
            end
            o.timed_out = !fin;
            // request lines still high through DONE; next cycle must be a clean IDLE
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            o.reissue = bus_req | stall;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_checks++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req got=%b exp=0", bus_req); else n_pass++;
        n_checks++; if (bus_we !== 1'b0) $display("FAIL reset_bus_we got=%b exp=0", bus_we); else n_pass++;
        n_checks++; if (bus_addr !== 32'h0) $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); else n_pass++;
        n_checks++; if (bus_be !== 4'h0) $display("FAIL reset_bus_be got=%h exp=0", bus_be); else n_pass++;
        n_checks++; if (bus_wdata !== 32'h0) $display("FAIL reset_bus_wdata got=%h exp=0", bus_wdata); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else n_pass++;
        n_checks++; if (bus_fault !== 1'b0) $display("FAIL reset_bus_fault got=%b exp=0", bus_fault); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        obs_t o;
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, o);
        n_checks++; if (o.baddr !== 32'h100) $display("FAIL sw_addr got=%h exp=100", o.baddr); else n_pass++;
        n_checks++; if (o.be !== 4'b1111) $display("FAIL sw_be got=%b exp=1111", o.be); else n_pass++;
        n_checks++; if (o.we !== 1'b1) $display("FAIL sw_we got=%b exp=1", o.we); else n_pass++;
        n_checks++; if (o.bwdata !== 32'hDEADBEEF) $display("FAIL sw_wdata got=%h exp=deadbeef", o.bwdata); else n_pass++;
        n_checks++; if (o.stall_cnt != 3) $display("FAIL sw_stall_cycles got=%0d exp=3", o.stall_cnt); else n_pass++;
        n_checks++; if (o.req_bad || o.done_req || o.reissue) $display("FAIL sw_handshake got=%b%b%b exp=000", o.req_bad, o.done_req, o.reissue); else n_pass++;

        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, o);
        n_checks++; if (o.rdata_done !== 32'hFFFFFF80) $display("FAIL lb got=%h exp=ffffff80", o.rdata_done); else n_pass++;
        n_checks++; if (o.be !== 4'b1000 || o.we !== 1'b0) $display("FAIL lb_be got=%b/%b exp=1000/0", o.be, o.we); else n_pass++;
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, o);
        n_checks++; if (o.rdata_done !== 32'h00000080) $display("FAIL lbu got=%h exp=00000080", o.rdata_done); else n_pass++;
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001ABCD, 1, o);
        n_checks++; if (o.rdata_done !== 32'hFFFF8001) $display("FAIL lh got=%h exp=ffff8001", o.rdata_done); else n_pass++;

        run_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1, o);
        n_checks++; if (o.mis !== 1'b1) $display("FAIL lh_mis got=%b exp=1", o.mis); else n_pass++;
        n_checks++; if (o.stall0 !== 1'b0 || o.rdata0 !== 32'h0) $display("FAIL lh_mis_resp got=%b/%h exp=0/0", o.stall0, o.rdata0); else n_pass++;
        n_checks++; if (o.req_bad) $display("FAIL lh_mis_req got=1 exp=0"); else n_pass++;

        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 1, o);
        n_checks++; if (o.be !== 4'b0010 || o.bwdata !== 32'hABABABAB) $display("FAIL sb got=%b/%h exp=0010/abababab", o.be, o.bwdata); else n_pass++;
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0, 3, o);
        n_checks++; if (o.be !== 4'b1100 || o.bwdata !== 32'h12341234) $display("FAIL sh got=%b/%h exp=1100/12341234", o.be, o.bwdata); else n_pass++;
        n_checks++; if (o.stall_cnt != 4) $display("FAIL sh_stall_cycles got=%0d exp=4", o.stall_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_bus();
        obs_t o;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus_req !== 1'b0) $display("FAIL midbus_reset_req got=%b exp=0", bus_req); else n_pass++;
        n_checks++; if (bus_addr !== 32'h0 || bus_be !== 4'h0) $display("FAIL midbus_reset_bus got=%h/%h exp=0/0", bus_addr, bus_be); else n_pass++;
        mem_read = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h13579BDF, 1, o);
        n_checks++; if (o.rdata_done !== 32'h13579BDF) $display("FAIL post_reset_lw got=%h exp=13579bdf", o.rdata_done); else n_pass++;
        n_checks++; if (o.stall_cnt != 2) $display("FAIL post_reset_stall got=%0d exp=2", o.stall_cnt); else n_pass++;
    endtask

    task automatic test_ack_outside_bus();
        obs_t o;
        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0BADF00D, 1, o);
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0BADF00D)
                $display("FAIL idle_ack cyc=%0d got=%b/%b/%h exp=0/0/0badf00d", i, bus_req, stall, rdata);
            else n_pass++;
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_random();
        obs_t o;
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] a, wd, rw, exp_rd;
        int sel, ack_at;
        for (int it = 0; it < 50; it++) begin
            sel = $urandom_range(0, 2);
            rd = (sel != 1); wr = (sel != 0);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            wd = $urandom; rw = $urandom;
            ack_at = $urandom_range(1, 3);
            run_access(rd, wr, f3, a, wd, rw, ack_at, o);
            if (model_mis(rd, f3, a)) begin
                n_checks++;
                if (o.mis !== 1'b1 || o.stall0 !== 1'b0 || o.rdata0 !== 32'h0 || o.req_bad)
                    $display("FAIL rand_mis it=%0d f3=%0d a=%h got=%b/%b/%h/%b exp=1/0/0/0", it, f3, a, o.mis, o.stall0, o.rdata0, o.req_bad);
                else n_pass++;
            end else begin
                n_checks++;
                if (o.mis !== 1'b0 || o.baddr !== (a & ~32'h3) || o.be !== model_be(f3, a) || o.we !== (wr & ~rd))
                    $display("FAIL rand_req it=%0d got=%b/%h/%b/%b exp=0/%h/%b/%b", it, o.mis, o.baddr, o.be, o.we, a & ~32'h3, model_be(f3, a), wr & ~rd);
                else n_pass++;
                n_checks++;
                if (o.stall_cnt != ack_at + 1 || o.req_bad || o.done_req || o.done_fault || o.reissue || o.timed_out)
                    $display("FAIL rand_hs it=%0d stall=%0d exp=%0d flags=%b%b%b%b%b exp=00000", it, o.stall_cnt, ack_at + 1, o.req_bad, o.done_req, o.done_fault, o.reissue, o.timed_out);
                else n_pass++;
                n_checks++;
                if (rd) begin
                    exp_rd = model_load(f3, a, rw);
                    if (o.rdata_done !== exp_rd) $display("FAIL rand_load it=%0d f3=%0d a=%h got=%h exp=%h", it, f3, a, o.rdata_done, exp_rd);
                    else n_pass++;
                end else begin
                    if (o.bwdata !== model_wdata(f3, wd)) $display("FAIL rand_store it=%0d f3=%0d got=%h exp=%h", it, f3, o.bwdata, model_wdata(f3, wd));
                    else n_pass++;
                end
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0, o);
        n_checks++; if (o.timed_out || o.stall_cnt != 5) $display("FAIL to_stall got=%0d/%b exp=5/0", o.stall_cnt, o.timed_out); else n_pass++;
        n_checks++; if (o.done_fault !== 1'b1 || o.done_req !== 1'b0) $display("FAIL to_fault got=%b/%b exp=1/0", o.done_fault, o.done_req); else n_pass++;
        n_checks++; if (o.rdata_done !== 32'h0) $display("FAIL to_rdata got=%h exp=0", o.rdata_done); else n_pass++;
        n_checks++; if (bus_fault !== 1'b0 || o.reissue) $display("FAIL to_pulse got=%b/%b exp=0/0", bus_fault, o.reissue); else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_bus();
        test_ack_outside_bus();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the single-cycle RV32I core.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one data-bus transaction per load/store with a req/ack handshake, stalling the core until it completes.
- Performs byte-lane steering, byte enables, load sign/zero extension and alignment checking.

Parameters:
- ADDR_W, 32, effective-address and bus-address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- TIMEOUT_CYC, 255, cycles in BUS before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  effective address (ALU result).
- wdata  in  DATA_W  store data (rs2).
- rdata  out  DATA_W  extended load data to the writeback mux.
- stall  out  1  freeze PC and register-file write.
- misaligned  out  1  illegal alignment or encoding; combinational.
- bus_fault  out  1  one-cycle pulse on bus timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 00).
- bus_be  out  4  byte enables.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- bus_ack  in  1  transaction complete.

Behaviour:
- Reset: rst_n low forces state IDLE immediately. All registered outputs go to 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, bus_fault. The async assertion drops bus_req mid-transaction.
- Access selection: access = mem_read | mem_write. If both are high, the access is treated as a load.
- Misalignment (evaluated in IDLE only):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=00.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 >= 011.
  - Response: misaligned=1, no bus_req, stall=0, rdata=0. The instruction retires with no memory effect.
- FSM states IDLE, BUS, DONE:
  - IDLE: on a legal access, assert stall combinationally in the same cycle. Register bus_addr, bus_be, bus_wdata, bus_we, funct3 and addr[1:0]. Go to BUS.
  - BUS: bus_req=1 and stall=1. All bus outputs are held stable until bus_ack. bus_ack in the first BUS cycle is legal (1-cycle wait). On bus_ack, register the extracted load data into rdata and go to DONE.
  - DONE: stall=0 for exactly one cycle so the instruction retires; rdata is valid. Go to IDLE. mem_read/mem_write still high in DONE must not reissue.
- Latency: a legal access with ack in the k-th BUS cycle stalls for k+1 cycles. Retire happens in the following DONE cycle.
- Byte enables and store data:
  - B: bus_be = 0001 << addr[1:0]; byte replicated to all 4 lanes.
  - H: bus_be = addr[1] ? 1100 : 0011; half replicated to both halves.
  - W: bus_be = 1111; data passed through.
  - Loads drive the same bus_be.
- Load extraction:
  - Select the lane using the latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- bus_ack outside BUS is ignored. rdata holds its last value outside DONE.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYC: drop bus_req, set rdata=0, pulse bus_fault for 1 cycle, go to DONE.
  - bus_ack arriving in the same cycle as the timeout wins.
- Undefined: the unit waits indefinitely in BUS, bus_fault is tied to 0, and no counter is built.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (IDLE=2'b00, BUS=2'b01, DONE=2'b10);
  - byte-enable constants.
- Sub-module load_extract: combinational lane select plus sign/zero extension. Inputs: word, addr[1:0], funct3. Output: 32-bit result. Reusable by the testbench model.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack in 2nd BUS cycle -> bus_addr=0x100, bus_be=1111, bus_we=1, stall high 3 cycles, low in DONE.
- LB addr=0x103, bus_rdata=0x80FF1234 -> rdata=0xFFFFFF80. Same access with LBU -> rdata=0x00000080.
- LH addr=0x102, bus_rdata=0x8001ABCD -> rdata=0xFFFF8001. LH addr=0x101 -> misaligned=1, bus_req never asserted, stall=0.
- SB addr=0x201, wdata=0x000000AB -> bus_be=0010, bus_wdata=0xABABABAB. SH addr=0x202, wdata=0x1234 -> bus_be=1100, bus_wdata=0x12341234.
- rst_n low during BUS -> bus_req=0 the same instant. After release, LW addr=0x0 with immediate ack completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYC=4, LW with no ack -> bus_fault pulses once after 4 BUS cycles, rdata=0, stall releases in DONE.
